complemento_a2: RTL and testbench



---
 rtl/complemento_a2_if.sv | 24 ++
 rtl/complemento_a2.sv | 58 +++++
 tb/tb_complemento_a2.sv | 117 +++++++++++
 3 files changed

// File: rtl/complemento_a2_if.sv
// Operand/result bus of the two's-complement operand conditioner.
interface complemento_a2_if #(
  parameter int unsigned WIDTH = 4
);
  logic             sumar;
  logic             restar;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             valid;
  logic             ovf;
  logic             err;

  // Producer of operations: drives selects and operand, observes the result.
  modport master (
    output sumar, restar, B,
    input  S, valid, ovf, err
  );

  // Conditioner side: consumes selects and operand, drives the result.
  modport slave (
    input  sumar, restar, B,
    output S, valid, ovf, err
  );
endinterface

// File: rtl/complemento_a2.sv
// Registered operand conditioner: passes B (add) or its two's complement
// (subtract) to S one cycle later, flagging illegal selects and the
// non-negatable most-negative value.
module complemento_a2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  complemento_a2_if.slave bus
);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] r_s;
  logic             r_valid;
  logic             r_ovf;
  logic             r_err;

  logic [WIDTH-1:0] w_neg;
  logic             w_is_min;

  // Negation as invert-plus-one; carry out of the increment is dropped.
  always_comb begin
    w_neg    = WIDTH'(~bus.B + WIDTH'(1));
    w_is_min = (bus.B == MOST_NEG);
  end

  // Select decode and result registers; reset wins over any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s     <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      unique case ({bus.sumar, bus.restar})
        2'b10: begin
          r_s     <= bus.B;
          r_valid <= 1'b1;
        end
        2'b01: begin
          r_s     <= w_neg;
          r_valid <= 1'b1;
          r_ovf   <= w_is_min;
        end
        2'b11: r_err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.S     = r_s;
  assign bus.valid = r_valid;
  assign bus.ovf   = r_ovf;
  assign bus.err   = r_err;
endmodule

// File: tb/tb_complemento_a2.sv
// Self-checking bench for complemento_a2: directed plan plus random ops
// against an arithmetic reference model.
module tb_complemento_a2;
  localparam int unsigned WIDTH = 4;
  localparam int          MOD   = 1 << WIDTH;

  logic clk;
  logic reset;

  complemento_a2_if #(.WIDTH(WIDTH)) bus ();

  complemento_a2 #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_miss;

  // Reference state
  int m_s;
  int m_valid;
  int m_ovf;
  int m_err;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs != exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference: result of one clock edge given the sampled inputs.
  task automatic model(input bit r, input bit su, input bit re, input int b);
    if (r) begin
      m_s = 0; m_valid = 0; m_ovf = 0; m_err = 0;
    end else if (su && !re) begin
      m_s = b; m_valid = 1; m_ovf = 0; m_err = 0;
    end else if (!su && re) begin
      m_s = (MOD - b) % MOD;
      m_valid = 1;
      m_ovf = (b == MOD / 2) ? 1 : 0;
      m_err = 0;
    end else begin
      m_valid = 0; m_ovf = 0; m_err = (su && re) ? 1 : 0;
    end
  endtask

  // Apply one operation across one edge and check all outputs.
  task automatic step(input string tag, input bit r, input bit su, input bit re, input int b);
    @(negedge clk);
    reset      = r;
    bus.sumar  = su;
    bus.restar = re;
    bus.B      = WIDTH'(b);
    @(posedge clk);
    #1;
    model(r, su, re, b);
    chk({tag, ".S"},     int'(bus.S),     m_s);
    chk({tag, ".valid"}, int'(bus.valid), m_valid);
    chk({tag, ".ovf"},   int'(bus.ovf),   m_ovf);
    chk({tag, ".err"},   int'(bus.err),   m_err);
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    m_s = 0; m_valid = 0; m_ovf = 0; m_err = 0;
    reset = 1'b1; bus.sumar = 1'b0; bus.restar = 1'b0; bus.B = '0;

    step("rst0", 1, 1, 0, 4'b0111);
    step("rst1", 1, 1, 0, 4'b0111);

    step("add_5",  0, 1, 0, 4'b0101);
    step("add_e",  0, 1, 0, 4'b1110);

    step("sub_3",  0, 0, 1, 4'b0011);
    step("sub_0",  0, 0, 1, 4'b0000);
    step("sub_f",  0, 0, 1, 4'b1111);

    step("ovf_8",  0, 0, 1, 4'b1000);
    step("ovf_1",  0, 0, 1, 4'b0001);

    step("ld_6",   0, 1, 0, 4'b0110);
    step("both",   0, 1, 1, 4'b0011);
    step("idle",   0, 0, 0, 4'b1001);

    step("bb_a",   0, 0, 1, 4'b0101);
    step("bb_rst", 1, 0, 1, 4'b0110);
    step("bb_b",   0, 0, 1, 4'b0010);

    for (int i = 0; i < 300; i++) begin
      bit r, su, re;
      int b;
      r  = ($urandom_range(0, 19) == 0);
      su = $urandom_range(0, 1);
      re = $urandom_range(0, 1);
      b  = $urandom_range(0, MOD - 1);
      step("rnd", r, su, re, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
